// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the d_cache miss handler: state encoding, block geometry
// and the in-block word address helper.
package cache_fill_fsm_pkg;
   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 16;
   localparam int BLK_WORDS = 8;
   localparam int CNT_W     = 3;
   localparam int OFF_LSB   = 1;
   localparam int OFF_MSB   = 3;

   localparam logic [ADDR_W-1:0] BASE_MASK = 16'hFFF0;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_FILL = 1'b1;

   typedef enum logic {
      IDLE = ST_IDLE,
      FILL = ST_FILL
   } state_t;

   // Offset add stays inside the block bits, so the tag field can never carry.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [CNT_W-1:0]  idx);
      logic [OFF_MSB:0] off;
      off = base[OFF_MSB:0] + {idx, 1'b0};
      return {base[ADDR_W-1:OFF_MSB+1], off};
   endfunction
endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for one side of a block fill; done latches once the last word
// of the block has been counted and holds until cleared.
module fill_counter
   import cache_fill_fsm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   logic at_tc;

   assign at_tc = (cnt == CNT_W'(BLK_WORDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (en && !done) begin
         cnt  <= cnt + CNT_W'(1);
         done <= at_tc;
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss handler between d_cache and main memory: fetches the 8-word block holding
// the miss address, streams words into the cache and writes the tag with the last.
//
// state | meaning
// IDLE  | waiting for a miss; all outputs low, stray memory responses dropped
// FILL  | issuing 8 requests and loading 8 returned words; pipeline stalled
module cache_fill_fsm
   import cache_fill_fsm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_data_valid,
   output logic              mem_enable,
   output logic [ADDR_W-1:0] mem_address,
   output logic              fsm_busy,
   output logic              load_data,
   output logic              load_tag,
   output logic [ADDR_W-1:0] cache_address,
   output logic [DATA_W-1:0] cache_data
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  issue_cnt, recv_cnt;
   logic              issue_done, recv_done;
   logic              in_fill, issue_en, recv_en, last_word;

   assign in_fill   = (state == FILL);
   assign issue_en  = in_fill && !issue_done;
   assign recv_en   = in_fill && mem_data_valid && !recv_done;
   assign last_word = recv_en && (recv_cnt == CNT_W'(BLK_WORDS - 1));

   // Counters sit cleared throughout IDLE so every fill starts from word 0.
   fill_counter u_issue_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!in_fill),
      .en    (issue_en),
      .cnt   (issue_cnt),
      .done  (issue_done)
   );

   fill_counter u_recv_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!in_fill),
      .en    (recv_en),
      .cnt   (recv_cnt),
      .done  (recv_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         base  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && miss_detected)
            base <= miss_address & BASE_MASK;
      end
   end

   always_comb begin
      state_nxt     = state;
      mem_enable    = 1'b0;
      mem_address   = '0;
      fsm_busy      = 1'b0;
      load_data     = 1'b0;
      load_tag      = 1'b0;
      cache_address = '0;
      cache_data    = '0;
      case (state)
         IDLE: begin
            if (miss_detected)
               state_nxt = FILL;
         end
         FILL: begin
            fsm_busy      = 1'b1;
            mem_enable    = issue_en;
            if (issue_en)
               mem_address = word_addr(base, issue_cnt);
            load_data     = recv_en;
            load_tag      = last_word;
            cache_address = word_addr(base, recv_cnt);
            cache_data    = mem_data;
            if (last_word)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle pipelined memory model and a
// one-line d_cache model fed from load_data / load_tag.
module tb_cache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = 16'h0;
   logic [15:0] mem_data;
   logic        mem_data_valid;
   logic        mem_enable;
   logic [15:0] mem_address;
   logic        fsm_busy;
   logic        load_data;
   logic        load_tag;
   logic [15:0] cache_address;
   logic [15:0] cache_data;

   int checks = 0;
   int passes = 0;

   cache_fill_fsm dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .miss_detected  (miss_detected),
      .miss_address   (miss_address),
      .mem_data       (mem_data),
      .mem_data_valid (mem_data_valid),
      .mem_enable     (mem_enable),
      .mem_address    (mem_address),
      .fsm_busy       (fsm_busy),
      .load_data      (load_data),
      .load_tag       (load_tag),
      .cache_address  (cache_address),
      .cache_data     (cache_data)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'h5A3C;
   endfunction

   // memory: request seen in cycle c returns in cycle c+4
   logic [3:0]  pv = 4'b0;
   logic [15:0] pa0 = 16'h0, pa1 = 16'h0, pa2 = 16'h0, pa3 = 16'h0;
   logic        force_v = 1'b0;
   logic [15:0] force_d = 16'h0;

   always @(posedge clk) begin
      pv  <= {pv[2:0], mem_enable};
      pa0 <= mem_address;
      pa1 <= pa0;
      pa2 <= pa1;
      pa3 <= pa2;
   end

   assign mem_data_valid = pv[3] | force_v;
   assign mem_data       = force_v ? force_d : (pv[3] ? mem_word(pa3) : 16'h0);

   // d_cache: one line, invalidated when a miss is handed to the FSM
   logic [15:0] cm_data [8];
   logic [11:0] cm_tag = 12'h0;
   logic        cm_valid = 1'b0;

   always @(posedge clk) begin
      if (miss_detected && !fsm_busy && rst_n) cm_valid <= 1'b0;
      if (load_data) cm_data[cache_address[3:1]] <= cache_data;
      if (load_tag) begin
         cm_tag   <= cache_address[15:4];
         cm_valid <= 1'b1;
      end
   end

   function automatic logic cache_hit(input logic [15:0] a);
      return cm_valid && (cm_tag == a[15:4]) && (cm_data[a[3:1]] == mem_word(a));
   endfunction

   logic [15:0] req_q[$];
   logic [15:0] ld_addr_q[$];
   logic [15:0] ld_data_q[$];
   logic [15:0] tag_q[$];
   int          busy_cycles;
   int          first_ld;
   logic        first_busy;
   logic        fill_timeout;

   // Runs one fill and records what the DUT presented; tests compare afterwards.
   task automatic do_fill(input logic [15:0] a, input logic hold_miss, input logic [15:0] a2);
      int cyc;
      req_q.delete();
      ld_addr_q.delete();
      ld_data_q.delete();
      tag_q.delete();
      busy_cycles = 0;
      first_ld    = -1;
      miss_detected = 1'b1;
      miss_address  = a;
      @(negedge clk);
      miss_detected = hold_miss;
      miss_address  = a2;
      first_busy = fsm_busy;
      cyc = 0;
      while (fsm_busy === 1'b1 && cyc < 40) begin
         if (mem_enable) req_q.push_back(mem_address);
         if (load_data) begin
            ld_addr_q.push_back(cache_address);
            ld_data_q.push_back(cache_data);
            if (first_ld < 0) first_ld = cyc;
         end
         if (load_tag) tag_q.push_back(cache_address);
         busy_cycles++;
         @(negedge clk);
         cyc++;
      end
      fill_timeout = (cyc >= 40);
      miss_detected = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (fsm_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", fsm_busy); else passes++;
      checks++; if (mem_enable !== 1'b0) $display("FAIL reset_mem_enable got %b want 0", mem_enable); else passes++;
      checks++; if (cache_address !== 16'h0) $display("FAIL reset_cache_address got %h want 0000", cache_address); else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      miss_detected = 1'b1;
      miss_address  = 16'h0608;
      @(negedge clk);
      miss_detected = 1'b0;
      @(negedge clk);
      checks++; if (fsm_busy !== 1'b1) $display("FAIL midrun_busy got %b want 1", fsm_busy); else passes++;
      checks++; if (mem_enable !== 1'b1) $display("FAIL midrun_mem_enable got %b want 1", mem_enable); else passes++;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (fsm_busy !== 1'b0) $display("FAIL async_reset_busy got %b want 0", fsm_busy); else passes++;
      checks++; if (mem_enable !== 1'b0) $display("FAIL async_reset_mem_enable got %b want 0", mem_enable); else passes++;
      checks++; if (load_data !== 1'b0) $display("FAIL async_reset_load_data got %b want 0", load_data); else passes++;
      checks++; if (load_tag !== 1'b0) $display("FAIL async_reset_load_tag got %b want 0", load_tag); else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_fill_basic();
      do_fill(16'h0608, 1'b0, 16'h0);
      checks++; if (fill_timeout) $display("FAIL basic_timeout got busy stuck want release"); else passes++;
      checks++; if (req_q.size() != 8) $display("FAIL basic_req_count got %0d want 8", req_q.size()); else passes++;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (req_q[i] !== 16'h0600 + 16'(2 * i))
            $display("FAIL basic_req%0d got %h want %h", i, req_q[i], 16'h0600 + 16'(2 * i));
         else passes++;
      end
      checks++; if (ld_addr_q.size() != 8) $display("FAIL basic_load_count got %0d want 8", ld_addr_q.size()); else passes++;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (ld_addr_q[i] !== 16'h0600 + 16'(2 * i) || ld_data_q[i] !== mem_word(16'h0600 + 16'(2 * i)))
            $display("FAIL basic_load%0d got %h/%h want %h/%h", i, ld_addr_q[i], ld_data_q[i],
                     16'h0600 + 16'(2 * i), mem_word(16'h0600 + 16'(2 * i)));
         else passes++;
      end
      checks++; if (tag_q.size() != 1 || tag_q[0] !== 16'h060E) $display("FAIL basic_tag got %0d entries first %h want 1 at 060e", tag_q.size(), tag_q[0]); else passes++;
      checks++; if (first_ld != 4) $display("FAIL basic_latency got %0d want 4", first_ld); else passes++;
      checks++; if (busy_cycles != 12) $display("FAIL basic_busy_cycles got %0d want 12", busy_cycles); else passes++;
      checks++; if (fsm_busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", fsm_busy); else passes++;
      checks++; if (!cache_hit(16'h0608)) $display("FAIL basic_hit got miss want hit at 0608"); else passes++;
   endtask

   task automatic test_miss_ignored();
      do_fill(16'h0608, 1'b1, 16'h8000);
      checks++; if (req_q.size() != 8) $display("FAIL ignore_req_count got %0d want 8", req_q.size()); else passes++;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (req_q[i] !== 16'h0600 + 16'(2 * i))
            $display("FAIL ignore_req%0d got %h want %h", i, req_q[i], 16'h0600 + 16'(2 * i));
         else passes++;
      end
      checks++; if (tag_q.size() != 1 || tag_q[0] !== 16'h060E) $display("FAIL ignore_tag got %0d entries first %h want 1 at 060e", tag_q.size(), tag_q[0]); else passes++;
      @(negedge clk);
      checks++; if (fsm_busy !== 1'b0) $display("FAIL ignore_no_refill got busy %b want 0", fsm_busy); else passes++;
   endtask

   task automatic test_reset_mid_fill();
      int loads, tags, cyc, late_loads;
      loads = 0; tags = 0; cyc = 0; late_loads = 0;
      miss_detected = 1'b1;
      miss_address  = 16'h0600;
      @(negedge clk);
      miss_detected = 1'b0;
      while (loads < 3 && cyc < 20) begin
         if (load_data) loads++;
         if (load_tag) tags++;
         @(negedge clk);
         cyc++;
      end
      checks++; if (loads != 3) $display("FAIL abort_loads_before got %0d want 3", loads); else passes++;
      rst_n = 1'b0;
      #1;
      checks++; if (load_data !== 1'b0) $display("FAIL abort_load_data got %b want 0", load_data); else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (load_data) late_loads++;
         if (load_tag) tags++;
         @(negedge clk);
      end
      checks++; if (tags != 0) $display("FAIL abort_tag got %0d want 0", tags); else passes++;
      checks++; if (late_loads != 0) $display("FAIL abort_dropped got %0d loads want 0", late_loads); else passes++;
      checks++; if (cache_hit(16'h0600)) $display("FAIL abort_still_miss got hit want miss at 0600"); else passes++;
      do_fill(16'h0600, 1'b0, 16'h0);
      checks++; if (req_q.size() != 8 || req_q[0] !== 16'h0600) $display("FAIL refetch_req got %0d first %h want 8 first 0600", req_q.size(), req_q[0]); else passes++;
      checks++; if (ld_addr_q.size() != 8 || ld_addr_q[0] !== 16'h0600) $display("FAIL refetch_load got %0d first %h want 8 first 0600", ld_addr_q.size(), ld_addr_q[0]); else passes++;
      checks++; if (!cache_hit(16'h0600)) $display("FAIL refetch_hit got miss want hit at 0600"); else passes++;
   endtask

   task automatic test_valid_in_idle();
      @(negedge clk);
      force_v = 1'b1;
      force_d = 16'hFACE;
      #1;
      checks++; if (load_data !== 1'b0) $display("FAIL idle_valid_load got %b want 0", load_data); else passes++;
      checks++; if (cache_data !== 16'h0) $display("FAIL idle_valid_data got %h want 0000", cache_data); else passes++;
      @(negedge clk);
      checks++; if (fsm_busy !== 1'b0) $display("FAIL idle_valid_busy got %b want 0", fsm_busy); else passes++;
      force_v = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      do_fill(16'hFFFE, 1'b0, 16'h0);
      checks++; if (req_q.size() != 8) $display("FAIL top_req_count got %0d want 8", req_q.size()); else passes++;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (req_q[i] !== 16'hFFF0 + 16'(2 * i) || ld_addr_q[i] !== 16'hFFF0 + 16'(2 * i))
            $display("FAIL top_addr%0d got %h/%h want %h", i, req_q[i], ld_addr_q[i], 16'hFFF0 + 16'(2 * i));
         else passes++;
      end
      checks++; if (tag_q.size() != 1 || tag_q[0] !== 16'hFFFE) $display("FAIL top_tag got %0d entries first %h want 1 at fffe", tag_q.size(), tag_q[0]); else passes++;
      checks++; if (!cache_hit(16'hFFFE)) $display("FAIL top_hit got miss want hit at fffe"); else passes++;
      do_fill(16'h8000, 1'b0, 16'h0);
      checks++; if (first_busy !== 1'b1) $display("FAIL b2b_start got busy %b want 1", first_busy); else passes++;
      checks++; if (req_q.size() != 8 || req_q[0] !== 16'h8000) $display("FAIL b2b_req got %0d first %h want 8 first 8000", req_q.size(), req_q[0]); else passes++;
      checks++; if (tag_q.size() != 1 || tag_q[0] !== 16'h800E) $display("FAIL b2b_tag got %0d entries first %h want 1 at 800e", tag_q.size(), tag_q[0]); else passes++;
      checks++; if (busy_cycles != 12) $display("FAIL b2b_busy_cycles got %0d want 12", busy_cycles); else passes++;
   endtask

   initial begin
      test_reset();
      test_fill_basic();
      test_miss_ignored();
      test_reset_mid_fill();
      test_valid_in_idle();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
